// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: state encoding,
// sizing constants and the index-to-one-hot helper.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map the index back to client numbering.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // 3-bit sum wraps mod 8, which is exactly the rotation we want
      rot[i] = req[ID_W'(i) + ptr];
    end
  end

  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
  end

  assign any    = |req;
  assign win_id = idx + ptr;

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with grant hold, explicit release and
// hold-time preemption. All outputs are registered.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt,
  output arb_state_t       fsm_state
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  // Handshake: a client raises req[i] and keeps it high; gnt[i] answers one
  // cycle later and stays until done, req[i] dropping, or the hold timeout.

  arb_state_t       state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [7:0]       hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  gnt_id_n;
  logic             gnt_valid_n;
  logic             preempt_n;
  logic [ID_W-1:0]  win_id;
  logic             any;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .win_id (win_id),
    .any    (any)
  );

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_cnt_n  = hold_cnt;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    preempt_n   = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n       = '0;
        gnt_id_n    = '0;
        gnt_valid_n = 1'b0;
        hold_cnt_n  = '0;
        if (en && any) begin
          state_n     = GRANT;
          gnt_n       = onehot_from_id(win_id);
          gnt_id_n    = win_id;
          gnt_valid_n = 1'b1;
          ptr_n       = win_id + 1'b1;
        end
      end
      GRANT: begin
        if (done || !req[gnt_id] || hold_cnt == HOLD_LAST) begin
          state_n     = IDLE;
          gnt_n       = '0;
          gnt_id_n    = '0;
          gnt_valid_n = 1'b0;
          hold_cnt_n  = '0;
          // a normal release wins over a timeout landing in the same cycle
          preempt_n   = !(done || !req[gnt_id]);
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
      preempt   <= preempt_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with HOLD_MAX=4: reset, rotation, pointer skip,
// timeout preemption, simultaneous release, enable gating, async reset.
module tb_rr_arb8;
  import arb_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             preempt;
  arb_state_t       fsm_state;

  int checks   = 0;
  int failures = 0;

  rr_arb8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt,
                           input logic [2:0] e_id, input logic e_valid, input logic e_pre);
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
    check({tag, ".preempt"}, 32'(preempt), 32'(e_pre));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // scoreboard of expected grant ids for the rotation sweep
  logic [ID_W-1:0] exp_q[$];

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    done  = 1'b0;
    repeat (3) step();
    check_out("in_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    check("in_reset.state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    check_out("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0);

    req = 8'h01;
    step();
    check_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    check("first_grant.state", 32'(fsm_state), 32'(GRANT));
    // release by dropping own request
    req = 8'h00;
    step();
    check_out("req_drop_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // rotation with all requesting
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back(ID_W'(i % 8));
    while (exp_q.size() > 0) begin
      logic [ID_W-1:0] e;
      e = exp_q.pop_front();
      step();
      check_out($sformatf("rot%0d", e), onehot_from_id(e), e, 1'b1, 1'b0);
      done = 1'b1;
      step();
      check_out("rot_gap", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
    end

    // pointer is 1; grant client 2, then 0 must beat 2 from ptr=3
    req = 8'h04;
    step();
    check_out("skip_setup", 8'h04, 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h05;
    step();
    check_out("skip_wrap", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    done = 1'b0;

    // timeout: exactly 4 cycles then preempt, then re-grant
    req = 8'h10;
    for (int c = 0; c < 4; c++) begin
      step();
      check_out($sformatf("hold_c%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    step();
    check_out("timeout_preempt", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check_out("regrant", 8'h10, 3'd4, 1'b1, 1'b0);

    // done in the timeout cycle: normal release
    repeat (3) step();
    check_out("last_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    step();
    check_out("done_at_timeout", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();
    check("preempt_quiet", 32'(preempt), 32'd0);

    // enable gating
    en  = 1'b0;
    req = 8'h80;
    for (int c = 0; c < 3; c++) begin
      step();
      check_out($sformatf("en_off%0d", c), 8'h00, 3'd0, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check_out("en_on", 8'h80, 3'd7, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_out("en_drop_in_grant", 8'h80, 3'd7, 1'b1, 1'b0);
    en   = 1'b1;
    done = 1'b1;
    step();
    done = 1'b0;

    // async reset mid-grant; ptr is 0 after client 7
    req = 8'h20;
    step();
    check_out("pre_async", 8'h20, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h21;
    step();
    rst_n = 1'b1;
    step();
    check_out("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-requester round-robin arbiter with grant hold, explicit release and hold-time preemption. It shares one downstream resource (bus, encoder datapath, memory port) among eight clients. It sits between the request lines and the resource mux. The issued grant drives the mux select through `gnt_id`.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset. Asserts immediately; release is synchronous to `clk`.
- `en` in 1: arbitration enable. When 0, no new grant is issued; a grant already issued continues.
- `req` in 8: request per client. Bit i is client i. A client holds its bit high until granted and done.
- `done` in 1: the current grantee releases the resource; sampled only in GRANT.
- `gnt` out 8: one-hot grant, or all zero.
- `gnt_id` out 3: binary index of the granted client; 0 when `gnt_valid`=0.
- `gnt_valid` out 1: a grant is active (`gnt` != 0).
- `preempt` out 1: one-cycle pulse marking that the previous grant ended by hold timeout.

## Operation
- States: IDLE, GRANT. Reset state is IDLE.
- All outputs are registered. Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0. Internally, `ptr`=0 and `hold_cnt`=0.
- **IDLE:** if `en`=1 and `req`!=0, pick a winner and go to GRANT.
  - The search starts at index `ptr` and runs upward with wrap: ptr, ptr+1, …, 7, 0, …, ptr-1. The first set bit wins.
  - On issue, `ptr` becomes (winner+1) mod 8 using 3-bit wrap arithmetic.
  - If `en`=0 or `req`=0, stay in IDLE with outputs at zero.
- **GRANT:** `gnt`/`gnt_id` stay constant. `hold_cnt` increments each cycle, starting at 0 on the first GRANT cycle.
  - Normal release: `done`=1, or `req[gnt_id]`=0. Go to IDLE with `preempt`=0.
  - Timeout release: `hold_cnt`=HOLD_MAX-1 with no normal release in the same cycle. Go to IDLE and pulse `preempt`=1 for the first IDLE cycle.
  - If `done` and timeout occur in the same cycle, it counts as a normal release (`preempt`=0).
  - `req` bits of other clients are ignored while in GRANT.
  - `en` falling during GRANT has no effect on the current grant.
- Fairness: the winner always gets lowest priority for the next decision. A client that stays requesting is served within 7 intervening grants.
- `req` changing in the same cycle as the IDLE decision: the value sampled at that clock edge is the one used.
- Reset asserted mid-grant clears all outputs and `ptr` asynchronously. The next decision after reset starts from index 0.

## Timing
- Request to grant: with the arbiter in IDLE, `req` sampled at edge k gives `gnt` valid after edge k (1-cycle latency).
- Release to next grant: `done` sampled at edge k drops `gnt` after edge k (one IDLE cycle). A pending requester is granted after edge k+1. The minimum grant-to-grant gap is 1 idle cycle.
- Grant duration: at least 1 cycle, at most HOLD_MAX cycles.
- `preempt` is high exactly in the IDLE cycle following a timeout and is low otherwise.
- There is no combinational path from `req`/`done` to any output.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding (IDLE=1'b0, GRANT=1'b1);
  - `N_REQ`=8 and `ID_W`=3;
  - a one-hot-from-index helper constant/function.
- One sub-module, `rr_pick8`, is combinational. Its inputs are `req[7:0]` and `ptr[2:0]`; its outputs are `win_id[2:0]` and `any`.
  - It rotates `req` right by `ptr`.
  - It applies a lowest-index-first priority pick.
  - It adds `ptr` back mod 8.
- The top holds the FSM, `ptr`, `hold_cnt`, and the output registers.

## Test plan
- Reset/idle: hold `rst_n`=0, then release with `req`=0 → all outputs 0. Then set `req`=8'h01 → `gnt`=8'h01, `gnt_id`=0, `gnt_valid`=1 one cycle later.
- Rotation: `req`=8'hFF held; pulse `done` on each grant → grant order 0,1,2,…,7,0 with a 1-cycle gap each time. `ptr` wraps 7→0.
- Pointer skip: after a grant to 2, set `req`=8'b0000_0101 → next grant goes to client 0 (wrap past 3..7), not client 2.
- Timeout: HOLD_MAX=4, `req`=8'h10 held, `done`=0 → `gnt`=8'h10 for exactly 4 cycles, then `preempt`=1 for 1 cycle, then client 4 is re-granted.
- Simultaneous events: `done`=1 in the timeout cycle → `preempt` stays 0. With `en`=0 and `req`=8'h80 → no grant until `en`=1, then a grant 1 cycle later.
- Async reset mid-grant: assert `rst_n`=0 between clock edges while `gnt`=8'h20 → outputs go to 0 immediately. After release with `req`=8'h21 → client 0 wins (`ptr` is back to 0).
